// File: rtl/axis_burst_m_pkg.sv
// Shared AXI-Stream definitions: burst FSM states, default widths and the
// handshake helper used by both the burst transmitter and the stream receiver.
package axis_pkg;

    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } axis_state_t;

    // A beat transfers on any rising edge where both valid and ready are high.
    function automatic logic axis_handshake(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/axis_burst_m_if.sv
// AXI-Stream bus bundle; the master drives valid/data/last, the slave drives ready.
interface axis_burst_m_if
    import axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_burst_m.sv
// AXI-Stream burst transmitter: on start, emits len+1 beats of an arithmetic
// sequence beginning at start_data, flags the final beat with tlast and pulses
// finish once that beat has been accepted. All outputs come straight from flops.
module axis_burst_m
    import axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W,
    parameter int LEN_W  = AXIS_LEN_W,
    parameter int STEP   = 1
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic [DATA_W-1:0] start_data,
    input  logic [LEN_W-1:0]  len,
    input  logic              hold,
    output logic              busy,
    output logic [LEN_W-1:0]  beat_cnt,
    output logic              finish,
    axis_burst_m_if.master    m_axis
);

    axis_state_t       r_state;
    logic              r_tvalid;
    logic [DATA_W-1:0] r_tdata;
    logic              r_tlast;
    logic [LEN_W-1:0]  r_beat_cnt;
    logic [LEN_W-1:0]  r_len;
    logic              r_busy;
    logic              r_finish;

    logic              w_hs;
    logic [LEN_W-1:0]  w_beat_next;

    assign w_hs        = axis_handshake(r_tvalid, m_axis.tready);
    // Only evaluated on non-last beats, so this can never exceed the latched len.
    assign w_beat_next = r_beat_cnt + LEN_W'(1);

    // Single FSM owning the beat counter, data register and every output flag.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state    <= IDLE;
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
            r_tlast    <= 1'b0;
            r_beat_cnt <= '0;
            r_len      <= '0;
            r_busy     <= 1'b0;
            r_finish   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_finish <= 1'b0;
                    if (start) begin
                        r_len      <= len;
                        r_tdata    <= start_data;
                        r_beat_cnt <= '0;
                        r_tlast    <= (len == '0);
                        r_tvalid   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= SEND;
                    end
                end
                SEND: begin
                    // Without a handshake everything holds, whatever hold does.
                    if (w_hs) begin
                        if (r_tlast) begin
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_finish <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_beat_cnt <= w_beat_next;
                            r_tdata    <= r_tdata + DATA_W'(STEP);
                            r_tlast    <= (w_beat_next == r_len);
                            if (hold) begin
                                r_tvalid <= 1'b0;
                                r_state  <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    // Next beat's data is already loaded; just re-raise valid.
                    if (!hold) begin
                        r_tvalid <= 1'b1;
                        r_state  <= SEND;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here, so it is dropped.
                    r_finish <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tlast  = r_tlast;
    assign busy          = r_busy;
    assign beat_cnt      = r_beat_cnt;
    assign finish        = r_finish;

endmodule

// File: tb/tb_axis_burst_m.sv
// Bench for axis_burst_m: directed bursts plus randomized ready/hold traffic,
// checked beat by beat against a reference that predicts each beat from
// start_data + index*STEP and the valid/gap rules of the stream protocol.
module tb_axis_burst_m;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
    localparam int STEP   = 1;

    logic              aclk = 1'b0;
    logic              areset;
    logic              start;
    logic [DATA_W-1:0] start_data;
    logic [LEN_W-1:0]  len;
    logic              hold;
    logic              busy;
    logic [LEN_W-1:0]  beat_cnt;
    logic              finish;

    int n_cmp  = 0;
    int n_fail = 0;

    axis_burst_m_if #(.DATA_W(DATA_W)) s_if ();

    axis_burst_m #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .STEP   (STEP)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .start      (start),
        .start_data (start_data),
        .len        (len),
        .hold       (hold),
        .busy       (busy),
        .beat_cnt   (beat_cnt),
        .finish     (finish),
        .m_axis     (s_if.master)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete burst. rmode: 0 ready=1, 1 fixed pattern, 2 random.
    // hmode: 0 no hold, 1 random hold, 2 hold high for the first 3 cycles.
    task automatic run_burst(input logic [DATA_W-1:0] sd, input int ln,
                             input int rmode, input int hmode, input bit extra_start);
        int   pat [6] = '{1, 0, 0, 1, 0, 1};
        int   idx     = 0;
        int   cyc     = 0;
        int   nbeats  = 0;
        bit   ev;
        bit   hs;
        bit   done    = 1'b0;
        logic rd;
        logic hd;
        logic [DATA_W-1:0] exp_data;

        start      = 1'b1;
        start_data = sd;
        len        = LEN_W'(ln);
        step();
        start      = 1'b0;
        start_data = $urandom;
        len        = LEN_W'($urandom);
        ev         = 1'b1;

        while (!done && cyc < 3000) begin
            chk("tvalid", 64'(s_if.tvalid), 64'(ev));
            chk("busy",   64'(busy),        64'd1);
            chk("finish_low", 64'(finish),  64'd0);
            if (ev) begin
                exp_data = sd + DATA_W'(idx * STEP);
                chk("tdata",    64'(s_if.tdata), 64'(exp_data));
                chk("tlast",    64'(s_if.tlast), 64'(idx == ln));
                chk("beat_cnt", 64'(beat_cnt),   64'(idx));
            end
            case (rmode)
                0:       rd = 1'b1;
                1:       rd = pat[cyc % 6] != 0;
                default: rd = 1'($urandom_range(0, 1));
            endcase
            case (hmode)
                0:       hd = 1'b0;
                1:       hd = ($urandom_range(0, 3) == 0);
                default: hd = (cyc < 3);
            endcase
            s_if.tready = rd;
            hold        = hd;
            start       = extra_start && (cyc == 1);
            start_data  = $urandom;
            hs          = ev && rd;
            step();
            start = 1'b0;
            cyc++;
            if (hs) begin
                nbeats++;
                if (idx == ln) done = 1'b1;
                else begin
                    idx++;
                    ev = !hd;
                end
            end else if (!ev) begin
                ev = !hd;
            end
        end

        chk("beats", 64'(nbeats), 64'(ln + 1));
        // Cycle right after the last handshake.
        chk("finish_pulse", 64'(finish),        64'd1);
        chk("done_tvalid",  64'(s_if.tvalid),   64'd0);
        chk("done_tlast",   64'(s_if.tlast),    64'd0);
        chk("done_busy",    64'(busy),          64'd1);
        s_if.tready = 1'b0;
        hold        = 1'b0;
        start       = extra_start;
        step();
        start = 1'b0;
        chk("idle_finish", 64'(finish),      64'd0);
        chk("idle_busy",   64'(busy),        64'd0);
        chk("idle_tvalid", 64'(s_if.tvalid), 64'd0);
        step();
        chk("no_queued_start", 64'(s_if.tvalid), 64'd0);
        chk("still_idle",      64'(busy),        64'd0);
        $display("burst sd=%08h len=%0d rmode=%0d hmode=%0d extra=%0d beats=%0d cycles=%0d",
                 sd, ln, rmode, hmode, extra_start, nbeats, cyc);
    endtask

    initial begin
        areset      = 1'b1;
        start       = 1'b0;
        start_data  = '0;
        len         = '0;
        hold        = 1'b0;
        s_if.tready = 1'b0;
        step();
        step();
        chk("rst_tvalid",   64'(s_if.tvalid), 64'd0);
        chk("rst_tlast",    64'(s_if.tlast),  64'd0);
        chk("rst_tdata",    64'(s_if.tdata),  64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt),    64'd0);
        chk("rst_busy",     64'(busy),        64'd0);
        chk("rst_finish",   64'(finish),      64'd0);
        areset = 1'b0;
        step();
        chk("post_rst_tvalid", 64'(s_if.tvalid), 64'd0);
        $display("reset released");

        run_burst(32'hA5A5_0001, 0, 0, 0, 1'b0);   // single beat
        run_burst(32'd10,        3, 0, 0, 1'b0);   // four beats back to back
        run_burst($urandom,      2, 1, 0, 1'b0);   // backpressure pattern
        run_burst(32'hFFFF_FFFF, 1, 0, 2, 1'b0);   // hold gap and data wrap
        run_burst($urandom,      4, 2, 0, 1'b1);   // start while busy / on finish
        run_burst($urandom,    255, 0, 0, 1'b0);   // maximum length
        for (int i = 0; i < 8; i++) begin
            run_burst($urandom, int'($urandom_range(0, 9)), 2, 1, 1'($urandom_range(0, 1)));
        end
        run_burst(32'hFFFF_FFFD, 255, 2, 1, 1'b0);

        // Reset in the middle of a 5-beat burst while beat 2 is stalled.
        start      = 1'b1;
        start_data = 32'h0000_1000;
        len        = 8'd4;
        step();
        start       = 1'b0;
        s_if.tready = 1'b1;
        step();
        step();
        s_if.tready = 1'b0;
        chk("pre_rst_beat",   64'(beat_cnt),    64'd2);
        chk("pre_rst_tvalid", 64'(s_if.tvalid), 64'd1);
        chk("pre_rst_tdata",  64'(s_if.tdata),  64'h1002);
        areset = 1'b1;
        step();
        areset = 1'b0;
        chk("midrst_tvalid", 64'(s_if.tvalid), 64'd0);
        chk("midrst_busy",   64'(busy),        64'd0);
        chk("midrst_finish", 64'(finish),      64'd0);
        chk("midrst_beat",   64'(beat_cnt),    64'd0);
        step();
        chk("midrst_no_finish", 64'(finish), 64'd0);
        $display("reset mid-burst applied");
        run_burst($urandom, 4, 2, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
